// File: rtl/axi_reg_slice.sv
// axi_reg_slice: AXI channel register slice with selectable timing break.
//   MODE 0 = bypass, 1 = forward slice, 2 = backward (skid) slice,
//   3 = full slice (2-entry FIFO). Payload is opaque, DW bits wide.
// Optional feature macro: AXI_RS_FLUSH_EN adds a synchronous flush input
// that drops all held beats and refuses upstream beats while asserted.
//
// Handshake: a beat moves on a side when valid && ready are both high at a
// posedge of clk. A source keeps valid high with stable data until it sees
// ready; ready may depend combinationally on the other side only where noted
// (MODE 0 and the MODE 1 m_ready path), never on valid of the same side.
// occ reports the number of beats held in slice storage, which doubles as the
// externally visible state of the slice.

module axi_reg_slice #(
  parameter int DW   = 64,
  parameter int MODE = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] m_data,
  input  logic          m_valid,
  output logic          m_ready,
  output logic [DW-1:0] s_data,
  output logic          s_valid,
  input  logic          s_ready,
`ifdef AXI_RS_FLUSH_EN
  input  logic          flush,
`endif
  output logic [1:0]    occ
);

  logic flush_i;

`ifdef AXI_RS_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  if (MODE == 0) begin : g_bypass
    // Pure wires; with flush held the channel is closed on both sides so a
    // beat can never be seen downstream without being taken upstream.
    assign s_data  = m_data;
    assign s_valid = m_valid & ~flush_i;
    assign m_ready = s_ready & ~flush_i;
    assign occ     = 2'd0;

  end else if (MODE == 1) begin : g_fwd
    logic          rvalid;
    logic [DW-1:0] rdata;

    assign s_valid = rvalid;
    assign s_data  = rdata;
    assign m_ready = (~rvalid | s_ready) & ~flush_i;
    assign occ     = {1'b0, rvalid};

    // Output register: load on upstream transfer, empty on downstream transfer.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rvalid <= 1'b0;
        rdata  <= '0;
      end else if (flush_i) begin
        rvalid <= 1'b0;
      end else if (m_valid && m_ready) begin
        rvalid <= 1'b1;
        rdata  <= m_data;
      end else if (s_ready) begin
        rvalid <= 1'b0;
      end
    end

  end else if (MODE == 2) begin : g_skid
    logic          kvalid;
    logic [DW-1:0] kdata;

    // Ready is the inverse of the skid flop, so upstream never sees s_ready.
    assign m_ready = ~kvalid & ~flush_i;
    assign s_valid = kvalid | (m_valid & ~flush_i);
    assign s_data  = kvalid ? kdata : m_data;
    assign occ     = {1'b0, kvalid};

    // Skid register: catch the beat that arrives while downstream stalls.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        kvalid <= 1'b0;
        kdata  <= '0;
      end else if (flush_i) begin
        kvalid <= 1'b0;
      end else if (s_ready) begin
        kvalid <= 1'b0;
      end else if (m_valid && m_ready) begin
        kvalid <= 1'b1;
        kdata  <= m_data;
      end
    end

  end else begin : g_full
    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic          push;
    logic          pop;

    // Both handshake outputs come straight from the count flops.
    assign s_valid = (count != 2'd0);
    assign m_ready = (count != 2'd2) & ~flush_i;
    assign s_data  = mem[rd_ptr];
    assign occ     = count;
    assign push    = m_valid & m_ready;
    assign pop     = s_valid & s_ready;

    // Two-entry FIFO; 1-bit pointers wrap naturally, count tracks fill level.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        mem[0] <= '0;
        mem[1] <= '0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= 2'd0;
      end else if (flush_i) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= m_data;
          wr_ptr      <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule
